// File: rtl/miriscv_wb_pkg.sv
// Shared widths and result types for the miriscv writeback unit.
package miriscv_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wd;
  } wb_entry_t;

endpackage

// File: rtl/miriscv_wb_fifo.sv
// Count-based FIFO buffering LSU results that lost arbitration on their transfer edge.
module miriscv_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk_i,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // A push while full is only legal when the same edge pops.
  assign do_push_s = push && (!full || pop);
  assign do_pop_s  = pop && !empty;
  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign pop_data  = mem_r[rd_ptr_r];

  // Storage array, written at the tail on every accepted push.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/miriscv_wb_unit.sv
// Writeback arbiter: ALU results first, then buffered/bypassed LSU results,
// plus a pending-destination scoreboard for load-use stalls.
module miriscv_wb_unit
  import miriscv_wb_pkg::*;
#(
  parameter int unsigned LSU_FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  reset,
  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_rd_i,
  input  logic [XLEN-1:0]       alu_wd_i,
  input  logic                  lsu_valid_i,
  input  logic [REG_ADDR_W-1:0] lsu_rd_i,
  input  logic [XLEN-1:0]       lsu_wd_i,
  output logic                  lsu_ready_o,
  input  logic                  issue_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  output logic                  stall_o,
  output logic                  rf_we_o,
  output logic [REG_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]       rf_wd_o,
  output logic                  waw_err_o
);

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  logic                  lsu_xfer_s;
  logic                  fifo_push_s;
  logic                  fifo_pop_s;
  logic [ENTRY_W-1:0]    fifo_head_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic                  sel_valid_s;
  wb_src_e               sel_src_s;
  wb_entry_t             sel_entry_s;
  logic                  rf_we_r;
  logic [REG_ADDR_W-1:0] rf_waddr_r;
  logic [XLEN-1:0]       rf_wd_r;
  wb_src_e               rf_src_r;
  logic [NUM_REGS-1:0]   pending_r;
  logic [NUM_REGS-1:0]   pending_nxt_s;
  logic                  waw_err_r;

  assign lsu_ready_o = !fifo_full_s;
  assign lsu_xfer_s  = lsu_valid_i && lsu_ready_o;

  miriscv_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_lsu_fifo (
    .clk_i     (clk_i),
    .reset     (reset),
    .push      (fifo_push_s),
    .push_data (ENTRY_W'({lsu_rd_i, lsu_wd_i})),
    .pop       (fifo_pop_s),
    .pop_data  (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // Arbitration; an LSU transfer is buffered unless it can bypass an empty FIFO.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_src_s   = SRC_ALU;
    sel_entry_s = '0;
    fifo_pop_s  = 1'b0;
    fifo_push_s = 1'b0;
    if (alu_valid_i) begin
      sel_valid_s = 1'b1;
      sel_entry_s = '{rd: alu_rd_i, wd: alu_wd_i};
      fifo_push_s = lsu_xfer_s;
    end else if (!fifo_empty_s) begin
      sel_valid_s = 1'b1;
      sel_src_s   = SRC_LSU;
      sel_entry_s = wb_entry_t'(fifo_head_s);
      fifo_pop_s  = 1'b1;
      fifo_push_s = lsu_xfer_s;
    end else if (lsu_xfer_s) begin
      sel_valid_s = 1'b1;
      sel_src_s   = SRC_LSU;
      sel_entry_s = '{rd: lsu_rd_i, wd: lsu_wd_i};
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Register-file write port; x0 results are consumed without a write strobe.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_ADDR_W{1'b0}};
      rf_wd_r    <= {XLEN{1'b0}};
      rf_src_r   <= SRC_ALU;
    end else begin
      rf_we_r <= sel_valid_s && (sel_entry_s.rd != {REG_ADDR_W{1'b0}});
      if (sel_valid_s) begin
        rf_waddr_r <= sel_entry_s.rd;
        rf_wd_r    <= sel_entry_s.wd;
        rf_src_r   <= sel_src_s;
      end
    end
  end

  // Next scoreboard value: load writeback clears, issue sets and wins, x0 never pending.
  always_comb begin
    pending_nxt_s = pending_r;
    if (rf_we_r && (rf_src_r == SRC_LSU)) begin
      pending_nxt_s[rf_waddr_r] = 1'b0;
    end else begin
      pending_nxt_s = pending_r;
    end
    if (issue_i) begin
      pending_nxt_s[issue_rd_i] = 1'b1;
    end else begin
      pending_nxt_s[0] = 1'b0;
    end
    pending_nxt_s[0] = 1'b0;
  end

  // Scoreboard and sticky write-after-write error flag.
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      pending_r <= {NUM_REGS{1'b0}};
      waw_err_r <= 1'b0;
    end else begin
      pending_r <= pending_nxt_s;
      if (alu_valid_i && (alu_rd_i != {REG_ADDR_W{1'b0}}) && pending_r[alu_rd_i]) begin
        waw_err_r <= 1'b1;
      end
    end
  end

  assign stall_o    = pending_r[rs1_i] || pending_r[rs2_i];
  assign rf_we_o    = rf_we_r;
  assign rf_waddr_o = rf_waddr_r;
  assign rf_wd_o    = rf_wd_r;
  assign waw_err_o  = waw_err_r;

endmodule

// File: tb/tb_miriscv_wb_unit.sv
// Directed self-checking bench for miriscv_wb_unit.
module tb_miriscv_wb_unit;

  logic        clk_i = 1'b0;
  logic        reset;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_wd_i;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_wd_i;
  logic        lsu_ready_o;
  logic        issue_i;
  logic [4:0]  issue_rd_i;
  logic [4:0]  rs1_i;
  logic [4:0]  rs2_i;
  logic        stall_o;
  logic        rf_we_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wd_o;
  logic        waw_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  miriscv_wb_unit #(.LSU_FIFO_DEPTH(2)) dut (
    .clk_i       (clk_i),
    .reset       (reset),
    .alu_valid_i (alu_valid_i),
    .alu_rd_i    (alu_rd_i),
    .alu_wd_i    (alu_wd_i),
    .lsu_valid_i (lsu_valid_i),
    .lsu_rd_i    (lsu_rd_i),
    .lsu_wd_i    (lsu_wd_i),
    .lsu_ready_o (lsu_ready_o),
    .issue_i     (issue_i),
    .issue_rd_i  (issue_rd_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .stall_o     (stall_o),
    .rf_we_o     (rf_we_o),
    .rf_waddr_o  (rf_waddr_o),
    .rf_wd_o     (rf_wd_o),
    .waw_err_o   (waw_err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset = 1'b1; alu_valid_i = 1'b0; alu_rd_i = 5'd0; alu_wd_i = 32'd0;
    lsu_valid_i = 1'b0; lsu_rd_i = 5'd0; lsu_wd_i = 32'd0;
    issue_i = 1'b0; issue_rd_i = 5'd0; rs1_i = 5'd0; rs2_i = 5'd0;
    tick(); tick();
    check("rst_we", {31'd0, rf_we_o}, 32'd0);
    check("rst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    check("rst_wd", rf_wd_o, 32'd0);
    check("rst_waw", {31'd0, waw_err_o}, 32'd0);
    check("rst_ready", {31'd0, lsu_ready_o}, 32'd1);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    reset = 1'b0;
    tick();

    // Load to x5 with pending-operand stall until its writeback edge
    issue_i = 1'b1; issue_rd_i = 5'd5; rs1_i = 5'd5;
    tick();
    issue_i = 1'b0;
    check("ld5_stall_pend", {31'd0, stall_o}, 32'd1);
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd5; lsu_wd_i = 32'hDEADBEEF;
    #1;
    check("ld5_ready", {31'd0, lsu_ready_o}, 32'd1);
    tick();
    lsu_valid_i = 1'b0;
    check("ld5_we", {31'd0, rf_we_o}, 32'd1);
    check("ld5_waddr", {27'd0, rf_waddr_o}, 32'd5);
    check("ld5_wd", rf_wd_o, 32'hDEADBEEF);
    check("ld5_stall_wb", {31'd0, stall_o}, 32'd1);
    tick();
    check("ld5_we_off", {31'd0, rf_we_o}, 32'd0);
    check("ld5_stall_clr", {31'd0, stall_o}, 32'd0);
    rs1_i = 5'd0;

    // ALU holds priority for 4 cycles while two loads fill the FIFO
    alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_wd_i = 32'h11;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd7; lsu_wd_i = 32'hA;
    tick();
    check("alu_e1_waddr", {27'd0, rf_waddr_o}, 32'd3);
    check("alu_e1_wd", rf_wd_o, 32'h11);
    lsu_rd_i = 5'd8; lsu_wd_i = 32'hB;
    check("fifo1_ready", {31'd0, lsu_ready_o}, 32'd1);
    tick();
    lsu_valid_i = 1'b0;
    check("fifo_full_ready", {31'd0, lsu_ready_o}, 32'd0);
    tick();
    tick();
    alu_valid_i = 1'b0;
    check("alu_e4_we", {31'd0, rf_we_o}, 32'd1);
    check("alu_e4_waddr", {27'd0, rf_waddr_o}, 32'd3);
    check("fifo_still_full", {31'd0, lsu_ready_o}, 32'd0);
    check("alu_no_waw", {31'd0, waw_err_o}, 32'd0);
    tick();
    check("pop7_waddr", {27'd0, rf_waddr_o}, 32'd7);
    check("pop7_wd", rf_wd_o, 32'hA);
    check("pop7_ready", {31'd0, lsu_ready_o}, 32'd1);
    tick();
    check("pop8_we", {31'd0, rf_we_o}, 32'd1);
    check("pop8_waddr", {27'd0, rf_waddr_o}, 32'd8);
    check("pop8_wd", rf_wd_o, 32'hB);
    tick();
    check("drain_we", {31'd0, rf_we_o}, 32'd0);

    // Load to x0 is consumed without a write and not retained
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd0; lsu_wd_i = 32'hFFFFFFFF;
    #1;
    check("x0_ready", {31'd0, lsu_ready_o}, 32'd1);
    tick();
    lsu_valid_i = 1'b0;
    check("x0_we", {31'd0, rf_we_o}, 32'd0);
    tick();
    check("x0_not_kept", {31'd0, rf_we_o}, 32'd0);

    // Re-issue of x9 on the edge its earlier load clears it: set wins
    issue_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    issue_i = 1'b0;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_wd_i = 32'h99;
    tick();
    lsu_valid_i = 1'b0;
    check("ld9_waddr", {27'd0, rf_waddr_o}, 32'd9);
    issue_i = 1'b1; issue_rd_i = 5'd9;
    tick();
    issue_i = 1'b0; rs2_i = 5'd9;
    #1;
    check("setwin_stall", {31'd0, stall_o}, 32'd1);
    tick();
    check("setwin_hold", {31'd0, stall_o}, 32'd1);

    // ALU write to a register with an outstanding load raises the sticky flag
    issue_i = 1'b1; issue_rd_i = 5'd4;
    tick();
    issue_i = 1'b0;
    check("waw_before", {31'd0, waw_err_o}, 32'd0);
    alu_valid_i = 1'b1; alu_rd_i = 5'd4; alu_wd_i = 32'h44;
    tick();
    alu_valid_i = 1'b0;
    check("waw_set", {31'd0, waw_err_o}, 32'd1);
    tick(); tick();
    check("waw_sticky", {31'd0, waw_err_o}, 32'd1);

    // Mid-cycle reset with two buffered loads and pending bits
    alu_valid_i = 1'b1; alu_rd_i = 5'd1; alu_wd_i = 32'h1;
    lsu_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_wd_i = 32'hC;
    issue_i = 1'b1; issue_rd_i = 5'd12;
    tick();
    issue_i = 1'b0; lsu_rd_i = 5'd11; lsu_wd_i = 32'hD;
    tick();
    alu_valid_i = 1'b0; lsu_valid_i = 1'b0; rs1_i = 5'd12;
    check("pre_rst_full", {31'd0, lsu_ready_o}, 32'd0);
    check("pre_rst_we", {31'd0, rf_we_o}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_we", {31'd0, rf_we_o}, 32'd0);
    check("arst_waddr", {27'd0, rf_waddr_o}, 32'd0);
    check("arst_wd", rf_wd_o, 32'd0);
    check("arst_waw", {31'd0, waw_err_o}, 32'd0);
    check("arst_ready", {31'd0, lsu_ready_o}, 32'd1);
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_we1", {31'd0, rf_we_o}, 32'd0);
    tick();
    check("post_rst_we2", {31'd0, rf_we_o}, 32'd0);
    check("post_rst_stall", {31'd0, stall_o}, 32'd0);
    check("post_rst_ready", {31'd0, lsu_ready_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
